keypad_emulator: RTL and testbench
==================================

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 SHALL have parameter BOUNCE_TICKS, default 8, cycles of contact bounce on press and on release (range 1..255).
REQ-002 SHALL have parameter ROW_LATENCY, default 1, cycles from keypad_col_in to keypad_row_out (fixed at 1; no other value is supported).
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid  in  1  press command offered.
REQ-006 SHALL have port cmd_ready  out  1  emulator idle, command acceptable.
REQ-007 SHALL have port cmd_key  in  4  key index; row = cmd_key[3:2], column = cmd_key[1:0].
REQ-008 SHALL have port cmd_hold  in  16  closed-contact hold time in cycles.
REQ-009 SHALL have port keypad_col_in  in  4  column drive from scanner, active-high, normally one-hot.
REQ-010 SHALL have port keypad_row_out  out  4  row sense returned to scanner, active-high; 4'b0000 = no key.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port done  out  1  one-cycle pulse at end of a press sequence.

Function
REQ-013 SHALL model one 4x4 matrix key per command: the switch closes, bounces, holds, bounces, opens.
REQ-014 SHALL set cmd_ready = 1 only in IDLE; a command is accepted on a rising edge where cmd_valid && cmd_ready.
REQ-015 SHALL latch cmd_key and cmd_hold at acceptance; input changes afterwards SHALL have no effect.
REQ-016 SHALL ignore cmd_valid while busy; commands are not queued.
REQ-017 SHALL have states IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, DONE.
REQ-018 Transition IDLE->PRESS_BOUNCE on acceptance.
REQ-019 PRESS_BOUNCE SHALL last exactly BOUNCE_TICKS cycles, then move to HOLD.
REQ-020 HOLD SHALL last exactly max(cmd_hold,1) cycles, then move to RELEASE_BOUNCE; cmd_hold = 0 SHALL be treated as 1.
REQ-021 RELEASE_BOUNCE SHALL last exactly BOUNCE_TICKS cycles, then move to DONE.
REQ-022 DONE SHALL last 1 cycle with done = 1, then move to IDLE.
REQ-023 Internal contact: 0 in IDLE and DONE; 1 in HOLD; in PRESS_BOUNCE and RELEASE_BOUNCE it is 1 on even bounce-counter values (0,2,4,...) and 0 on odd values. The bounce counter SHALL reset to 0 on entry to each bounce state.
REQ-024 keypad_row_out SHALL be registered: next value = one-hot(row) when contact && keypad_col_in[column], else 4'b0000. This gives 1-cycle latency from keypad_col_in.
REQ-025 Columns other than the key's column SHALL not affect keypad_row_out. When several columns are driven, only keypad_col_in[column] is tested.
REQ-026 Counters SHALL be 16-bit; no wrap-around is reachable within one state.

Reset
REQ-027 While rst = 1 at a rising edge, the block SHALL enter IDLE with contact = 0, keypad_row_out = 4'b0000, busy = 0, done = 0, cmd_ready = 1 (from the following cycle), and counters = 0.
REQ-028 Reset mid-sequence SHALL abort the sequence without asserting done; no latched key SHALL survive reset.

Configuration
REQ-029 Macro KEYPAD_EMULATOR_BOUNCE_EN: when defined, PRESS_BOUNCE and RELEASE_BOUNCE behave per REQ-019/021/023.
REQ-030 When KEYPAD_EMULATOR_BOUNCE_EN is undefined, the bounce states SHALL not exist. The sequence SHALL be IDLE->HOLD->DONE->IDLE with a clean contact, and BOUNCE_TICKS SHALL be ignored.

Verification
REQ-031 BOUNCE_EN defined, BOUNCE_TICKS=4, key 4'b0110 (row 1, col 2), hold 10, keypad_col_in fixed 4'b0100. Required: keypad_row_out follows 0010,0000,0010,0000, then 0010 for 10 cycles, then 0010,0000,0010,0000, then 0000. done pulses once, 19 cycles after acceptance.
REQ-032 Same command with keypad_col_in rotating 0001->0010->0100->1000, one step per cycle. Required: keypad_row_out = 0010 only in the cycle after col_in = 0100 while contact = 1, otherwise 0000.
REQ-033 cmd_valid held high with a second command during busy. Required: the second command is not accepted until the cycle after done; cmd_ready = 0 throughout.
REQ-034 cmd_hold = 0, BOUNCE_EN undefined. Required: HOLD lasts 1 cycle, done asserts 2 cycles after acceptance, keypad_row_out is high for exactly 1 cycle.
REQ-035 rst asserted in the 5th HOLD cycle. Required: next cycle keypad_row_out = 0000, busy = 0, cmd_ready = 1, and done is never asserted.
REQ-036 Closed loop with the team's keypad scanner (debounce 20). Each of the 16 keys pressed with hold 200. Required: the scanner reports the matching row in the matching column and key_pressed asserts.

Source files
------------

// File: rtl/keypad_emulator.sv
// Emulates one 4x4 matrix key per command: close, bounce, hold, bounce, open.
// Bounce phases exist only when KEYPAD_EMULATOR_BOUNCE_EN is defined.
module keypad_emulator #(
  parameter int BOUNCE_TICKS = 8,
  parameter int ROW_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  input  logic [3:0]  keypad_col_in,
  output logic [3:0]  keypad_row_out,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  if (BOUNCE_TICKS < 1 || BOUNCE_TICKS > 255 || ROW_LATENCY != 1) begin : g_param_check
    $error("keypad_emulator: unsupported BOUNCE_TICKS or ROW_LATENCY");
  end

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_PRESS_BOUNCE   = 3'd1,
    S_HOLD           = 3'd2,
    S_RELEASE_BOUNCE = 3'd3,
    S_DONE           = 3'd4
  } state_t;
  localparam logic [15:0] BOUNCE_LAST = 16'(BOUNCE_TICKS - 1);
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HOLD = 3'd2,
    S_DONE = 3'd4
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic [3:0]  key_q, key_d;
  logic [3:0]  row_q, row_d;
  logic        busy_q, done_q, ready_q;
  logic        contact;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so offers made while busy are simply ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    hold_d  = hold_q;
    key_d   = key_q;
    contact = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          key_d  = cmd_key;
          hold_d = (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
          state_d = S_PRESS_BOUNCE;
`else
          state_d = S_HOLD;
`endif
        end
      end
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
      S_PRESS_BOUNCE: begin
        contact = ~cnt_q[0];
        if (cnt_q == BOUNCE_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_RELEASE_BOUNCE: begin
        contact = ~cnt_q[0];
        if (cnt_q == BOUNCE_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
`endif
      S_HOLD: begin
        contact = 1'b1;
        if (cnt_q == hold_q - 16'd1) begin
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
          state_d = S_RELEASE_BOUNCE;
`else
          state_d = S_DONE;
`endif
          cnt_d = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Only the key's own column is tested; other driven columns are irrelevant.
    row_d = (contact && keypad_col_in[key_q[1:0]]) ? (4'b0001 << key_q[3:2]) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      key_q   <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      key_q   <= key_d;
      row_q   <= row_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      ready_q <= (state_d == S_IDLE);
    end
  end

  assign keypad_row_out = row_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign cmd_ready      = ready_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: per-cycle phase-queue model plus directed literal traces.
// Works in both builds (KEYPAD_EMULATOR_BOUNCE_EN defined or not).
module tb_keypad_emulator;

  localparam int BT = 4;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  localparam int HOLD_START = BT;
  localparam int LIT_N      = 20;
  localparam logic [31:0] LIT_HOT  = 32'b00101_1111111111_01010;
  localparam logic [31:0] LIT_DONE = 32'h0004_0000;
`else
  localparam int HOLD_START = 0;
  localparam int LIT_N      = 12;
  localparam logic [31:0] LIT_HOT  = 32'b0111_1111_1110;
  localparam logic [31:0] LIT_DONE = 32'b0100_0000_0000;
`endif
  localparam int DONE_J = 2 * HOLD_START + 3;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_key;
  logic [15:0] cmd_hold;
  logic [3:0]  keypad_col_in;
  logic [3:0]  keypad_row_out;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  keypad_emulator #(.BOUNCE_TICKS(BT), .ROW_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_key(cmd_key), .cmd_hold(cmd_hold), .keypad_col_in(keypad_col_in),
    .keypad_row_out(keypad_row_out), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: one queue entry per remaining busy cycle, {contact, done}; empty = IDLE.
  logic [1:0] exp_q[$];
  logic [3:0] m_key;
  logic [3:0] m_row = 4'b0000;

  task automatic model_accept(input logic [15:0] h);
    int hc;
    hc = (h == 16'd0) ? 1 : int'(h);
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    for (int k = 0; k < BT; k++) exp_q.push_back((k % 2 == 0) ? 2'b10 : 2'b00);
`endif
    for (int k = 0; k < hc; k++) exp_q.push_back(2'b10);
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    for (int k = 0; k < BT; k++) exp_q.push_back((k % 2 == 0) ? 2'b10 : 2'b00);
`endif
    exp_q.push_back(2'b01);
  endtask

  always @(posedge clk) begin : model_blk
    logic cur_contact;
    if (rst) begin
      exp_q.delete();
      m_row = 4'b0000;
      m_key = 4'b0000;
    end else begin
      cur_contact = (exp_q.size() != 0) ? exp_q[0][1] : 1'b0;
      m_row = (cur_contact && keypad_col_in[m_key[1:0]]) ? (4'b0001 << m_key[3:2]) : 4'b0000;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      else if (cmd_valid) begin
        m_key = cmd_key;
        model_accept(cmd_hold);
      end
    end
  end

  // scoreboard compare, every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("row", keypad_row_out, m_row);
      check("busy", busy, exp_q.size() != 0);
      check("ready", cmd_ready, exp_q.size() == 0);
      check("done", done, (exp_q.size() != 0) && exp_q[0][0]);
    end
  end

  // driver tasks (called at a negedge while idle; return at negedge after acceptance)
  task automatic send(input logic [3:0] key, input logic [15:0] hold);
    cmd_valid = 1'b1;
    cmd_key   = key;
    cmd_hold  = hold;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_key   = 4'($urandom);
    cmd_hold  = 16'($urandom);
  endtask

  task automatic capture(input int n, output logic [31:0] hot, output logic [31:0] dn,
                         output logic [3:0] rows_or);
    hot = '0; dn = '0; rows_or = '0;
    for (int j = 0; j < n; j++) begin
      hot[j] = (keypad_row_out != 4'b0000);
      dn[j]  = done;
      rows_or = rows_or | keypad_row_out;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] hot, dn;
    logic [3:0]  ro;
    int          cnt;
    logic        flag;

    cmd_valid = 1'b0; cmd_key = '0; cmd_hold = '0; keypad_col_in = '0; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_row", keypad_row_out, 4'b0000);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // fixed column, key row 1 col 2, hold 10
    keypad_col_in = 4'b0100;
    send(4'b0110, 16'd10);
    capture(LIT_N, hot, dn, ro);
    check("fixed_row_trace", hot, LIT_HOT);
    check("fixed_done_trace", dn, LIT_DONE);
    check("fixed_row_value", ro, 4'b0010);
    repeat (3) @(negedge clk);

`ifndef KEYPAD_EMULATOR_BOUNCE_EN
    send(4'b0110, 16'd0);
    capture(4, hot, dn, ro);
    check("hold0_row_trace", hot, 32'b0010);
    check("hold0_done_trace", dn, 32'b0010);
    repeat (3) @(negedge clk);
`endif

    // rotating column drive
    keypad_col_in = 4'b0001;
    send(4'b0110, 16'd10);
    cnt = 0;
    for (int j = 0; j < 30; j++) begin
      if (keypad_row_out != 4'b0000) cnt++;
      keypad_col_in = {keypad_col_in[2:0], keypad_col_in[3]};
      @(negedge clk);
    end
    check("rotate_hot_count", cnt, 3);
    repeat (3) @(negedge clk);

    // second command offered continuously while busy
    keypad_col_in = 4'b1111;
    cmd_valid = 1'b1; cmd_key = 4'b0000; cmd_hold = 16'd3;
    @(negedge clk);
    cmd_key = 4'b1111; cmd_hold = 16'd2;
    flag = 1'b0;
    for (int j = 0; j <= DONE_J; j++) begin
      if (cmd_ready) flag = 1'b1;
      if (j == DONE_J) check("held_done_at", done, 1'b1);
      @(negedge clk);
    end
    check("held_ready_low", flag, 1'b0);
    check("held_idle_gap", busy, 1'b0);
    @(negedge clk);
    check("held_second_accept", busy, 1'b1);
    cmd_valid = 1'b0;
    repeat (30) @(negedge clk);

    // reset during the fifth hold cycle
    keypad_col_in = 4'b0010;
    send(4'b1001, 16'd20);
    repeat (HOLD_START + 4) @(negedge clk);
    check("pre_reset_row", keypad_row_out, 4'b0100);
    rst = 1'b1;
    @(negedge clk);
    check("abort_row", keypad_row_out, 4'b0000);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    flag = 1'b0;
    for (int j = 0; j < 30; j++) begin
      if (done) flag = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", flag, 1'b0);

    // randomized traffic
    for (int j = 0; j < 800; j++) begin
      cmd_valid = ($urandom_range(0, 9) < 3);
      cmd_key   = 4'($urandom_range(0, 15));
      cmd_hold  = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) keypad_col_in = 4'($urandom_range(0, 15));
      else keypad_col_in = 4'b0001 << $urandom_range(0, 3);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    repeat (60) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
